// File: rtl/kmac_msgfifo_ctrl_if.sv
// Handshake bundle between the register-write packer and the SHA3 message port.
// The design uses the slave view; the producer/consumer side uses master.
interface kmac_msgfifo_ctrl_if #(
    parameter int MsgWidth     = 64,
    parameter int RegIntfWidth = 32
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [RegIntfWidth-1:0] wr_data;
    logic                    wr_last;
    logic                    msg_valid;
    logic                    msg_ready;
    logic [MsgWidth-1:0]     msg_data;
    logic [MsgWidth/8-1:0]   msg_strb;
    logic                    msg_last;

    modport slave (
        input  wr_valid, wr_data, wr_last, msg_ready,
        output wr_ready, msg_valid, msg_data, msg_strb, msg_last
    );

    modport master (
        output wr_valid, wr_data, wr_last, msg_ready,
        input  wr_ready, msg_valid, msg_data, msg_strb, msg_last
    );
endinterface

// File: rtl/kmac_msgfifo_ctrl.sv
// KMAC message FIFO: packs 32-bit register writes into 64-bit words and queues
// them in a Depth-entry circular buffer feeding the SHA3 core.
module kmac_msgfifo_ctrl #(
    parameter int MsgWidth     = 64,
    parameter int RegIntfWidth = 32,
    parameter int Depth        = 10,
    parameter int DepthW       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    kmac_msgfifo_ctrl_if.slave bus,
    output logic [DepthW-1:0] fifo_depth,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              idle
);
    localparam int StrbW     = MsgWidth / 8;
    localparam int HalfStrbW = StrbW / 2;
    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);
    localparam logic [DepthW-1:0] PtrLast  = DepthW'(Depth - 1);

    typedef struct packed {
        logic [MsgWidth-1:0] data;
        logic [StrbW-1:0]    strb;
        logic                last;
    } entry_t;

    entry_t                  mem [Depth];
    entry_t                  push_entry;
    entry_t                  head;
    logic [DepthW-1:0]       wptr;
    logic [DepthW-1:0]       rptr;
    logic [DepthW-1:0]       count;
    logic                    half;
    logic [RegIntfWidth-1:0] low;
    logic                    accept;
    logic                    push;
    logic                    pop;

    // Depth is not a power of two, so wrap needs an explicit compare.
    function automatic logic [DepthW-1:0] ptr_inc(input logic [DepthW-1:0] p);
        return (p == PtrLast) ? '0 : p + DepthW'(1);
    endfunction

    // Accept whenever there is room, even if this write only fills the low half.
    assign bus.wr_ready  = (count < DepthMax);
    assign bus.msg_valid = (count != '0);
    assign accept        = bus.wr_valid && bus.wr_ready;
    assign push          = accept && (half || bus.wr_last);
    assign pop           = bus.msg_valid && bus.msg_ready;

    always_comb begin
        push_entry = '0;
        if (half) begin
            push_entry.data = {bus.wr_data, low};
            push_entry.strb = '1;
            push_entry.last = bus.wr_last;
        end else begin
            push_entry.data = {{RegIntfWidth{1'b0}}, bus.wr_data};
            push_entry.strb = {{HalfStrbW{1'b0}}, {HalfStrbW{1'b1}}};
            push_entry.last = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            half  <= 1'b0;
            low   <= '0;
        end else if (clear) begin
            // Flush wins over any same-cycle accept or pop.
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            half  <= 1'b0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + DepthW'(1);
                2'b01:   count <= count - DepthW'(1);
                default: count <= count;
            endcase
            if (accept) begin
                if (!half && !bus.wr_last) begin
                    low  <= bus.wr_data;
                    half <= 1'b1;
                end else begin
                    half <= 1'b0;
                end
            end
        end
    end

    // Storage carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= push_entry;
    end

    assign head         = mem[rptr];
    assign bus.msg_data = head.data;
    assign bus.msg_strb = head.strb;
    assign bus.msg_last = bus.msg_valid && head.last;

    assign fifo_depth = count;
    assign fifo_full  = (count == DepthMax);
    assign fifo_empty = (count == '0);
    assign idle       = (count == '0) && !half;

    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= DepthMax);
    a_ptr_range:   assert property (@(posedge clk) disable iff (rst)
                                    (wptr < DepthMax) && (rptr < DepthMax));
endmodule

// File: tb/tb_kmac_msgfifo_ctrl.sv
// Randomized and directed bench for kmac_msgfifo_ctrl against a queue-based model.
module tb_kmac_msgfifo_ctrl;
    localparam int DEPTH = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] fifo_depth;
    logic       fifo_full;
    logic       fifo_empty;
    logic       idle;

    kmac_msgfifo_ctrl_if #(.MsgWidth(64), .RegIntfWidth(32)) bus ();

    kmac_msgfifo_ctrl #(
        .MsgWidth(64), .RegIntfWidth(32), .Depth(DEPTH), .DepthW(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bus        (bus),
        .fifo_depth (fifo_depth),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: a queue of words plus the pending low half.
    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } ent_t;

    ent_t        q[$];
    bit          m_half = 1'b0;
    logic [31:0] m_low  = '0;
    ent_t        m_e;
    int          m_n;
    bit          m_acc;
    bit          m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            q.delete();
            m_half = 1'b0;
        end else begin
            m_n   = q.size();
            m_acc = bus.wr_valid && (m_n < DEPTH);
            m_pop = bus.msg_ready && (m_n > 0);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                if (m_half) begin
                    m_e.d = {bus.wr_data, m_low}; m_e.s = 8'hFF; m_e.l = bus.wr_last;
                    q.push_back(m_e);
                    m_half = 1'b0;
                end else if (bus.wr_last) begin
                    m_e.d = {32'h0, bus.wr_data}; m_e.s = 8'h0F; m_e.l = 1'b1;
                    q.push_back(m_e);
                end else begin
                    m_low  = bus.wr_data;
                    m_half = 1'b1;
                end
            end
        end
    end

    int c_n;
    always @(negedge clk) begin
        c_n = q.size();
        chk("wr_ready",   64'(bus.wr_ready),  64'(c_n < DEPTH));
        chk("msg_valid",  64'(bus.msg_valid), 64'(c_n != 0));
        chk("fifo_depth", 64'(fifo_depth),    64'(c_n));
        chk("fifo_full",  64'(fifo_full),     64'(c_n == DEPTH));
        chk("fifo_empty", 64'(fifo_empty),    64'(c_n == 0));
        chk("idle",       64'(idle),          64'((c_n == 0) && !m_half));
        chk("msg_last",   64'(bus.msg_last),  64'((c_n != 0) ? q[0].l : 1'b0));
        if (c_n != 0) begin
            chk("msg_data", bus.msg_data,      q[0].d);
            chk("msg_strb", 64'(bus.msg_strb), 64'(q[0].s));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] d, input bit l, input bit r);
        bus.wr_valid  = v;
        bus.wr_data   = d;
        bus.wr_last   = l;
        bus.msg_ready = r;
    endtask

    int thresh;

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        set_in(0, '0, 0, 0);
        repeat (3) step();
        chk("rst_wr_ready", 64'(bus.wr_ready),  64'(1));
        chk("rst_valid",    64'(bus.msg_valid), 64'(0));
        chk("rst_last",     64'(bus.msg_last),  64'(0));
        rst = 1'b0;
        step();
        chk("idle_wr_ready", 64'(bus.wr_ready),  64'(1));
        chk("idle_valid",    64'(bus.msg_valid), 64'(0));
        chk("idle_depth",    64'(fifo_depth),    64'(0));
        chk("idle_idle",     64'(idle),          64'(1));

        // Pack two writes into one word
        set_in(1, 32'h11111111, 0, 0);
        step();
        chk("pack_idle0",  64'(idle),          64'(0));
        chk("pack_valid0", 64'(bus.msg_valid), 64'(0));
        set_in(1, 32'h22222222, 1, 0);
        step();
        set_in(0, '0, 0, 0);
        chk("pack_valid", 64'(bus.msg_valid), 64'(1));
        chk("pack_data",  bus.msg_data,       64'h2222222211111111);
        chk("pack_strb",  64'(bus.msg_strb),  64'(8'hFF));
        chk("pack_last",  64'(bus.msg_last),  64'(1));
        set_in(0, '0, 0, 1);
        step();
        set_in(0, '0, 0, 0);
        chk("pack_pop_depth", 64'(fifo_depth), 64'(0));

        // Odd tail
        set_in(1, 32'hA5A5A5A5, 1, 0);
        step();
        set_in(0, '0, 0, 0);
        chk("tail_data", bus.msg_data,      64'h00000000A5A5A5A5);
        chk("tail_strb", 64'(bus.msg_strb), 64'(8'h0F));
        chk("tail_last", 64'(bus.msg_last), 64'(1));
        set_in(0, '0, 0, 1);
        step();

        // Fill to full, then pop 3 / push 3 across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            set_in(1, $urandom, 0, 0);
            step();
        end
        set_in(0, '0, 0, 0);
        chk("full_depth",    64'(fifo_depth),   64'(10));
        chk("full_full",     64'(fifo_full),    64'(1));
        chk("full_wr_ready", 64'(bus.wr_ready), 64'(0));
        set_in(1, 32'hDEADBEEF, 1, 0);
        step();
        chk("full_drop_depth", 64'(fifo_depth), 64'(10));
        set_in(0, '0, 0, 1);
        repeat (3) step();
        chk("pop3_depth", 64'(fifo_depth), 64'(7));
        for (int i = 0; i < 6; i++) begin
            set_in(1, $urandom, i[0], 0);
            step();
        end
        set_in(0, '0, 0, 0);
        chk("wrap_depth", 64'(fifo_depth), 64'(10));
        set_in(0, '0, 0, 1);
        repeat (10) step();
        chk("drain_depth", 64'(fifo_depth), 64'(0));

        // Steady push/pop at depth 5
        for (int i = 0; i < 5; i++) begin
            set_in(1, $urandom, 1, 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1, $urandom, 1, 1);
            step();
            chk("steady_depth", 64'(fifo_depth), 64'(5));
        end
        set_in(0, '0, 0, 1);
        repeat (5) step();

        // Clear with a half word held and a colliding write + pop
        for (int i = 0; i < 9; i++) begin
            set_in(1, $urandom, 0, 0);
            step();
        end
        set_in(0, '0, 0, 0);
        chk("pre_clear_depth", 64'(fifo_depth), 64'(4));
        chk("pre_clear_idle",  64'(idle),       64'(0));
        clear = 1'b1;
        set_in(1, 32'hCAFEF00D, 1, 1);
        step();
        clear = 1'b0;
        set_in(0, '0, 0, 0);
        chk("clear_depth", 64'(fifo_depth),    64'(0));
        chk("clear_idle",  64'(idle),          64'(1));
        chk("clear_valid", 64'(bus.msg_valid), 64'(0));

        // Async reset mid-stream
        for (int i = 0; i < 6; i++) begin
            set_in(1, $urandom, i == 5 ? 1'b0 : 1'b1, 0);
            step();
        end
        set_in(0, '0, 0, 0);
        chk("pre_rst_depth", 64'(fifo_depth), 64'(5));
        #2 rst = 1'b1;
        #1;
        chk("arst_depth",    64'(fifo_depth),    64'(0));
        chk("arst_idle",     64'(idle),          64'(1));
        chk("arst_valid",    64'(bus.msg_valid), 64'(0));
        chk("arst_wr_ready", 64'(bus.wr_ready),  64'(1));
        step();
        rst = 1'b0;
        step();

        // Randomized traffic with varying drain rates
        for (int i = 0; i < 3000; i++) begin
            thresh = 1 + ((i / 300) % 7);
            clear  = ($urandom % 97) == 0;
            set_in(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 8) < thresh);
            step();
        end
        clear = 1'b0;
        set_in(0, '0, 0, 1);
        repeat (12) step();
        chk("final_depth", 64'(fifo_depth), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
